// File: rtl/pc_sequencer.sv
// Fetch program-counter generator: exception > stall > branch > return > sequential.
// Define PC_SEQUENCER_RAS_EN to build the return-address stack; without it is_call/is_ret are ignored.
module pc_sequencer #(
    parameter int                  PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = PC_WIDTH'(32'h0000_1000),
    parameter int                  INCR      = 4,
    parameter int                  RAS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                PCSrc,
    input  logic [PC_WIDTH-1:0] PC_branch,
    input  logic                exc_req,
    input  logic [PC_WIDTH-1:0] exc_vector,
    input  logic                is_call,
    input  logic                is_ret,
    output logic [PC_WIDTH-1:0] PC,
    output logic [PC_WIDTH-1:0] next_PC,
    output logic                redirect,
    output logic [4:0]          ras_count,
    output logic                ras_underflow
);
    localparam logic [PC_WIDTH-1:0] INCR_W = PC_WIDTH'(INCR);

    logic [PC_WIDTH-1:0] pc_q;
    logic                redirect_q;
    logic                advance;
    logic                ret_hit;
    logic [PC_WIDTH-1:0] ret_target;

    assign next_PC  = pc_q + INCR_W;
    assign PC       = pc_q;
    assign redirect = redirect_q;
    assign advance  = !exc_req && !stall && !PCSrc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            redirect_q <= 1'b0;
        end else if (exc_req) begin
            pc_q       <= exc_vector;
            redirect_q <= 1'b1;
        end else if (stall) begin
            redirect_q <= 1'b0;
        end else if (PCSrc) begin
            pc_q       <= PC_branch;
            redirect_q <= 1'b1;
        end else if (ret_hit) begin
            pc_q       <= ret_target;
            redirect_q <= 1'b1;
        end else begin
            pc_q       <= next_PC;
            redirect_q <= 1'b0;
        end
    end

`ifdef PC_SEQUENCER_RAS_EN
    localparam int         PTR_W   = $clog2(RAS_DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(RAS_DEPTH);

    logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0]    top_q;
    logic [4:0]          cnt_q;
    logic                underflow_q;
    logic                ras_we;
    logic [PTR_W-1:0]    ras_wa;

    // Circular buffer: a push past full lands on the oldest slot, so overwrite needs no extra logic.
    always_comb begin
        ret_hit    = advance && is_ret && (cnt_q != 5'd0);
        ret_target = ras_q[top_q];
        ras_we     = advance && is_call;
        ras_wa     = ret_hit ? top_q : top_q + PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (ras_we) begin
            ras_q[ras_wa] <= next_PC;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top_q       <= '0;
            cnt_q       <= 5'd0;
            underflow_q <= 1'b0;
        end else if (exc_req) begin
            top_q       <= '0;
            cnt_q       <= 5'd0;
            underflow_q <= 1'b0;
        end else if (stall || PCSrc) begin
            underflow_q <= 1'b0;
        end else if (ret_hit) begin
            underflow_q <= 1'b0;
            // Call+return swaps the top in place; a plain return pops.
            if (!is_call) begin
                top_q <= top_q - PTR_W'(1);
                cnt_q <= cnt_q - 5'd1;
            end
        end else begin
            underflow_q <= is_ret;
            if (is_call) begin
                top_q <= top_q + PTR_W'(1);
                if (cnt_q != DEPTH_C) begin
                    cnt_q <= cnt_q + 5'd1;
                end
            end
        end
    end

    assign ras_count     = cnt_q;
    assign ras_underflow = underflow_q;
`else
    logic unused_ok;

    assign ret_hit       = 1'b0;
    assign ret_target    = next_PC;
    assign ras_count     = 5'd0;
    assign ras_underflow = 1'b0;
    assign unused_ok     = ^{is_call, is_ret, advance, 5'(RAS_DEPTH)};
`endif

endmodule
